// File: rtl/text_streamer_pkg.sv
`default_nettype none
// =============================================================================
// text_streamer_pkg : shared state encoding and pipeline constants
// Rev 1.0
// =============================================================================
package text_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int MEM_LAT    = 1;
   localparam int SKID_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/text_streamer_if.sv
`default_nettype none
// =============================================================================
// text_streamer_if : memory read port plus valid/ready output stream
// Rev 1.0
// =============================================================================
interface text_streamer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (
      output mem_addr, mem_rd_en, m_data, m_valid, m_last,
      input  mem_q, m_ready
   );

   modport slave (
      input  mem_addr, mem_rd_en, m_data, m_valid, m_last,
      output mem_q, m_ready
   );
endinterface
`default_nettype wire

// File: rtl/text_streamer_skid_buf.sv
`default_nettype none
// =============================================================================
// text_streamer_skid_buf : 2-entry FIFO absorbing the memory read latency
// Rev 1.0
// =============================================================================
module text_streamer_skid_buf #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 2
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             flush_i,
   input  wire logic             push_i,
   input  wire logic [WIDTH-1:0] push_data_i,
   input  wire logic             pop_i,
   output logic      [WIDTH-1:0] pop_data_o,
   output logic      [1:0]       count_o,
   output logic                  empty_o,
   output logic                  full_o
);
   logic [WIDTH-1:0] data_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) data_q[i] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            data_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_i) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   assign pop_data_o = data_q[rd_ptr_q];
   assign count_o    = count_q;
   assign empty_o    = (count_q == 2'd0);
   assign full_o     = (count_q == 2'(DEPTH));
endmodule
`default_nettype wire

// File: rtl/text_streamer.sv
`default_nettype none
// =============================================================================
// text_streamer : streams an address window of a sync RAM/ROM as valid/ready
// Rev 1.0
// =============================================================================
module text_streamer
   import text_streamer_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 255,
   parameter int CNT_W      = 16
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             start_i,
   input  wire logic             abort_i,
   input  wire logic             loop_en_i,
   text_streamer_if.master       bus,
   output logic                  busy_o,
   output logic                  done_o,
   output logic      [CNT_W-1:0] words_sent_o
);
   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [MEM_LAT-1:0] lat_q, lat_d;
   logic [MEM_LAT-1:0] tag_q, tag_d;
   logic [CNT_W-1:0]   words_q, words_d;

   logic               w_rd_en;
   logic               w_pop;
   logic               w_empty;
   logic               w_full;
   logic [1:0]         w_count;
   logic [DATA_W:0]    w_head;
   logic               w_at_end;
   int                 w_credit;

   assign w_pop    = !w_empty && bus.m_ready;
   assign w_at_end = (addr_q == ADDR_W'(END_ADDR));
   // Occupancy the buffer will have after this edge if no new read is issued.
   assign w_credit = int'(w_count) + $countones(lat_q) - int'(w_pop);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lat_d   = lat_q << 1;
      tag_d   = tag_q << 1;
      words_d = w_pop ? words_q + CNT_W'(1) : words_q;
      w_rd_en = 1'b0;
      if (abort_i) begin
         state_d = ST_IDLE;
         addr_d  = ADDR_W'(START_ADDR);
         lat_d   = '0;
         tag_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_d = ST_STREAM;
                  addr_d  = ADDR_W'(START_ADDR);
                  words_d = '0;
               end
            end
            ST_STREAM: begin
               if (w_credit < SKID_DEPTH && !(w_full && !w_pop)) begin
                  w_rd_en = 1'b1;
                  lat_d   = lat_d | MEM_LAT'(1);
                  tag_d   = tag_d | MEM_LAT'(w_at_end);
                  if (w_at_end) begin
                     addr_d = ADDR_W'(START_ADDR);
                     if (!loop_en_i) state_d = ST_DRAIN;
                  end else begin
                     addr_d = addr_q + ADDR_W'(1);
                  end
               end
            end
            ST_DRAIN: begin
               // Finish on the same edge that hands off the final word.
               if (w_credit == 0) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= ADDR_W'(START_ADDR);
         lat_q   <= '0;
         tag_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         tag_q   <= tag_d;
         words_q <= words_d;
      end
   end

   text_streamer_skid_buf #(
      .WIDTH (DATA_W + 1),
      .DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (abort_i),
      .push_i      (lat_q[MEM_LAT-1]),
      .push_data_i ({tag_q[MEM_LAT-1], bus.mem_q}),
      .pop_i       (w_pop),
      .pop_data_o  (w_head),
      .count_o     (w_count),
      .empty_o     (w_empty),
      .full_o      (w_full)
   );

   assign bus.mem_addr  = addr_q;
   assign bus.mem_rd_en = w_rd_en;
   assign bus.m_data    = w_head[DATA_W-1:0];
   assign bus.m_last    = w_head[DATA_W];
   assign bus.m_valid   = !w_empty;
   assign busy_o        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
   assign done_o        = (state_q == ST_DONE);
   assign words_sent_o  = words_q;
endmodule
`default_nettype wire
